// File: rtl/dffram_bist.sv
// March C- self-test controller for one single-port DFFRAM macro.
// Define DFFRAM_BIST_FAIL_LOG_EN to add first-failure address/syndrome/element capture.
module dffram_bist #(
    parameter int          A_WIDTH = 11,
    parameter logic [31:0] BG      = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic               MEM_EN,
    output logic [3:0]         MEM_WE,
    output logic [A_WIDTH-1:0] MEM_A,
    output logic [31:0]        MEM_Di,
    input  logic [31:0]        MEM_Do
`ifdef DFFRAM_BIST_FAIL_LOG_EN
    ,
    output logic [A_WIDTH-1:0] fail_addr,
    output logic [31:0]        fail_data,
    output logic [2:0]         fail_elem
`endif
);
    typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE} state_t;
    localparam logic [A_WIDTH-1:0] LAST = '1;

    // state/addr/phase describe the access currently on the RAM port
    state_t             state, state_nx;
    logic [A_WIDTH-1:0] addr, addr_nx;
    logic               phase, phase_nx;
    logic               fail, chk_vld, mism, accept;
    logic [31:0]        chk_exp, rd_exp, acc_di;
    logic               acc_en, acc_we;

    assign accept = (state == IDLE || state == DONE) && start;

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        phase_nx = phase;
        case (state)
            IDLE, DONE: if (start) begin state_nx = M0; addr_nx = '0; phase_nx = 1'b0; end
            M0: if (addr == LAST) begin state_nx = M1; addr_nx = '0; end
                else addr_nx = addr + 1'b1;
            M1: if (!phase) phase_nx = 1'b1;
                else begin
                    phase_nx = 1'b0;
                    if (addr == LAST) begin state_nx = M2; addr_nx = '0; end
                    else addr_nx = addr + 1'b1;
                end
            M2: if (!phase) phase_nx = 1'b1;
                else begin
                    phase_nx = 1'b0;
                    if (addr == LAST) state_nx = M3;   // M3 starts at the top, address holds
                    else addr_nx = addr + 1'b1;
                end
            M3: if (!phase) phase_nx = 1'b1;
                else begin
                    phase_nx = 1'b0;
                    if (addr == '0) begin state_nx = M4; addr_nx = LAST; end
                    else addr_nx = addr - 1'b1;
                end
            M4: if (!phase) phase_nx = 1'b1;
                else begin
                    phase_nx = 1'b0;
                    if (addr == '0) state_nx = M5;
                    else addr_nx = addr - 1'b1;
                end
            M5: if (addr == LAST) begin state_nx = FLUSH; addr_nx = '0; end
                else addr_nx = addr + 1'b1;
            FLUSH:   state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // decode of the access to launch on the next cycle
    always_comb begin
        acc_en = state_nx inside {M0, M1, M2, M3, M4, M5};
        acc_we = (state_nx == M0) || phase_nx;
        acc_di = 32'h0;
        if (acc_we) acc_di = (state_nx == M1 || state_nx == M3) ? ~BG : BG;
        rd_exp = (state == M2 || state == M4) ? ~BG : BG;
    end

    assign mism = chk_vld && (MEM_Do != chk_exp);

`ifdef DFFRAM_BIST_FAIL_LOG_EN
    logic [A_WIDTH-1:0] chk_addr;
    logic [2:0]         chk_elem, elem;
    always_comb begin
        case (state)
            M1:      elem = 3'd1;
            M2:      elem = 3'd2;
            M3:      elem = 3'd3;
            M4:      elem = 3'd4;
            M5:      elem = 3'd5;
            default: elem = 3'd0;
        endcase
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            addr    <= '0;
            phase   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            MEM_EN  <= 1'b0;
            MEM_WE  <= 4'h0;
            MEM_A   <= '0;
            MEM_Di  <= 32'h0;
            fail    <= 1'b0;
            chk_vld <= 1'b0;
            chk_exp <= 32'h0;
`ifdef DFFRAM_BIST_FAIL_LOG_EN
            chk_addr  <= '0;
            chk_elem  <= 3'd0;
            fail_addr <= '0;
            fail_data <= 32'h0;
            fail_elem <= 3'd0;
`endif
        end else begin
            state   <= state_nx;
            addr    <= addr_nx;
            phase   <= phase_nx;
            MEM_EN  <= acc_en;
            MEM_WE  <= {4{acc_we}};
            MEM_A   <= addr_nx;
            MEM_Di  <= acc_di;
            busy    <= acc_en || (state_nx == FLUSH);
            // read on the port this cycle -> compare its data next cycle
            chk_vld <= MEM_EN && (MEM_WE == 4'h0);
            chk_exp <= rd_exp;
`ifdef DFFRAM_BIST_FAIL_LOG_EN
            chk_addr <= MEM_A;
            chk_elem <= elem;
`endif
            if (accept) begin
                done <= 1'b0;
                pass <= 1'b0;
                fail <= 1'b0;
`ifdef DFFRAM_BIST_FAIL_LOG_EN
                fail_addr <= '0;
                fail_data <= 32'h0;
                fail_elem <= 3'd0;
`endif
            end else begin
                if (mism) fail <= 1'b1;
                if (state == FLUSH) begin
                    done <= 1'b1;
                    pass <= ~(fail | mism);
                end
`ifdef DFFRAM_BIST_FAIL_LOG_EN
                if (mism && !fail) begin
                    fail_addr <= chk_addr;
                    fail_data <= MEM_Do ^ chk_exp;
                    fail_elem <= chk_elem;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_dffram_bist.sv
// Bench for dffram_bist at N=16: fault-injecting RAM model, table vectors,
// random faults checked against an algorithmic March C- reference.
module tb_dffram_bist;
    localparam int N = 16;

    typedef struct {
        bit          stk;
        logic [3:0]  sa;
        logic [31:0] sm;
        bit          al;
        logic [3:0]  src;
        logic [3:0]  dst;
    } fault_t;

    typedef struct {
        fault_t      f;
        bit          xp;
        logic [3:0]  xa;
        logic [31:0] xd;
        logic [2:0]  xe;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic a_busy, a_done, a_pass, a_en, b_busy, b_done, b_pass, b_en;
    logic [3:0]  a_we, a_a, b_we, b_a;
    logic [31:0] a_di, a_do, b_di, b_do;
    fault_t flt;
    logic [31:0] mem_a [N];
    logic [31:0] mem_b [N];
    int n_chk = 0, n_pass = 0;
    int done_k, busy_bad, m3_bad;
    logic [31:0] b_m1_di;
    logic [3:0]  b_m1_we;

`ifdef DFFRAM_BIST_FAIL_LOG_EN
    logic [3:0]  a_fa, b_fa;
    logic [31:0] a_fd, b_fd;
    logic [2:0]  a_fe, b_fe;
`endif

    always #5 clk = ~clk;

    dffram_bist #(.A_WIDTH(4), .BG(32'h0000_0000)) dut_a (
        .CLK(clk), .RST(rst), .start(start), .busy(a_busy), .done(a_done), .pass(a_pass),
        .MEM_EN(a_en), .MEM_WE(a_we), .MEM_A(a_a), .MEM_Di(a_di), .MEM_Do(a_do)
`ifdef DFFRAM_BIST_FAIL_LOG_EN
        , .fail_addr(a_fa), .fail_data(a_fd), .fail_elem(a_fe)
`endif
    );

    dffram_bist #(.A_WIDTH(4), .BG(32'hA5A5_5A5A)) dut_b (
        .CLK(clk), .RST(rst), .start(start), .busy(b_busy), .done(b_done), .pass(b_pass),
        .MEM_EN(b_en), .MEM_WE(b_we), .MEM_A(b_a), .MEM_Di(b_di), .MEM_Do(b_do)
`ifdef DFFRAM_BIST_FAIL_LOG_EN
        , .fail_addr(b_fa), .fail_data(b_fd), .fail_elem(b_fe)
`endif
    );

    // RAM under test for dut_a: registered read, read-before-write, optional faults
    always @(posedge clk) begin
        if (a_en) begin
            a_do <= mem_a[a_a] | ((flt.stk && a_a == flt.sa) ? flt.sm : 32'h0);
            if (a_we != 4'h0) begin
                mem_a[a_a] <= a_di;
                if (flt.al && a_a == flt.src) mem_a[flt.dst] <= a_di;
            end
        end
    end

    always @(posedge clk) begin
        if (b_en) begin
            b_do <= mem_b[b_a];
            if (b_we != 4'h0) mem_b[b_a] <= b_di;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic fault_t no_fault();
        fault_t f;
        f.stk = 0; f.sa = 0; f.sm = 0; f.al = 0; f.src = 0; f.dst = 0;
        return f;
    endfunction

    // March C- run straight from the element list on a faulty array
    function automatic void march_ref(input logic [31:0] bg, input fault_t f,
                                      output bit p, output logic [3:0] fa,
                                      output logic [31:0] fd, output logic [2:0] fe);
        logic [31:0] m [N];
        logic [31:0] v, rv, wv;
        int a;
        bit up, rd, wr;
        p = 1; fa = 0; fd = 0; fe = 0;
        for (int e = 0; e < 6; e++) begin
            up = (e == 0 || e == 1 || e == 2 || e == 5);
            rd = (e >= 1);
            wr = (e <= 4);
            rv = (e == 2 || e == 4) ? ~bg : bg;
            wv = (e == 1 || e == 3) ? ~bg : bg;
            for (int i = 0; i < N; i++) begin
                a = up ? i : N - 1 - i;
                if (rd) begin
                    v = m[a] | ((f.stk && a == int'(f.sa)) ? f.sm : 32'h0);
                    if (v != rv && p) begin
                        p = 0; fa = 4'(a); fd = v ^ rv; fe = 3'(e);
                    end
                end
                if (wr) begin
                    m[a] = wv;
                    if (f.al && a == int'(f.src)) m[f.dst] = wv;
                end
            end
        end
    endfunction

    // one run from a start pulse; abort exercises the re-pulse at 40 and RST at 80
    task automatic run(input fault_t f, input int pre, input bit abort);
        bit stop;
        int o;
        flt = f;
        repeat (pre) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        done_k = 0; busy_bad = 0; m3_bad = 0; stop = 0;
        for (int k = 1; k <= 200 && done_k == 0 && !stop; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (abort) begin
                if (k == 40) start = 1'b1;
                if (k == 41) start = 1'b0;
                if (k == 45) begin
                    chk("restart_ignored_addr", 32'(a_a), 32'd14);
                    chk("restart_ignored_we", 32'(a_we), 32'h0);
                end
                if (k == 80) rst = 1'b1;
                if (k == 81) begin
                    chk("rst_mid_busy", 32'(a_busy), 32'h0);
                    chk("rst_mid_done", 32'(a_done), 32'h0);
                    chk("rst_mid_en", 32'(a_en), 32'h0);
                    chk("rst_mid_port", {a_we, a_a, a_di[23:0]}, 32'h0);
                    rst = 1'b0;
                    stop = 1;
                end
            end else begin
                if ((k <= 161) != a_busy) busy_bad++;
                if (k >= 81 && k <= 112) begin
                    o = k - 81;
                    if (!a_en || a_a != 4'(15 - o / 2) ||
                        a_we != ((o % 2) ? 4'hF : 4'h0) ||
                        a_di != ((o % 2) ? 32'hFFFF_FFFF : 32'h0)) m3_bad++;
                end
                if (k == 18) begin b_m1_di = b_di; b_m1_we = b_we; end
                if (a_done) done_k = k;
            end
        end
        if (!abort) begin
            chk("done_cycle", 32'(done_k), 32'd162);
            chk("busy_window", 32'(busy_bad), 32'd0);
            chk("m3_sequence", 32'(m3_bad), 32'd0);
        end
    endtask

    initial begin
        vec_t tbl [4];
        fault_t f;
        bit xp;
        logic [3:0] xa;
        logic [31:0] xd;
        logic [2:0] xe;

        tbl[0].f = no_fault(); tbl[0].xp = 1; tbl[0].xa = 0; tbl[0].xd = 0; tbl[0].xe = 0;
        tbl[1].f = no_fault(); tbl[1].f.stk = 1; tbl[1].f.sa = 7; tbl[1].f.sm = 32'h0000_0020;
        tbl[1].xp = 0; tbl[1].xa = 7; tbl[1].xd = 32'h0000_0020; tbl[1].xe = 1;
        tbl[2].f = no_fault(); tbl[2].f.al = 1; tbl[2].f.src = 3; tbl[2].f.dst = 11;
        tbl[2].xp = 0; tbl[2].xa = 11; tbl[2].xd = 32'hFFFF_FFFF; tbl[2].xe = 1;
        tbl[3].f = no_fault(); tbl[3].f.stk = 1; tbl[3].f.sa = 0; tbl[3].f.sm = 32'h8000_0000;
        tbl[3].xp = 0; tbl[3].xa = 0; tbl[3].xd = 32'h8000_0000; tbl[3].xe = 1;
        flt = no_fault();

        repeat (3) @(negedge clk);
        chk("reset_busy_done_pass", {29'h0, a_busy, a_done, a_pass}, 32'h0);
        chk("reset_port", {27'h0, a_en, a_we}, 32'h0);
        chk("reset_addr_di", {a_a, a_di[27:0]}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run(tbl[i].f, i, 0);
            chk($sformatf("tbl%0d_pass", i), 32'(a_pass), 32'(tbl[i].xp));
`ifdef DFFRAM_BIST_FAIL_LOG_EN
            chk($sformatf("tbl%0d_fail_addr", i), 32'(a_fa), 32'(tbl[i].xa));
            chk($sformatf("tbl%0d_fail_data", i), a_fd, tbl[i].xd);
            chk($sformatf("tbl%0d_fail_elem", i), 32'(a_fe), 32'(tbl[i].xe));
`endif
            if (i == 0) begin
                chk("bg_m1_wdata", b_m1_di, 32'h5A5A_A5A5);
                chk("bg_m1_we", 32'(b_m1_we), 32'hF);
                chk("bg_pass", 32'(b_pass), 32'h1);
                repeat (5) @(negedge clk);
                chk("done_held", {30'h0, a_done, a_busy}, 32'h2);
            end
        end

        // re-pulse ignored, RST mid-run, then a clean run
        run(no_fault(), 2, 1);
        run(no_fault(), 1, 0);
        chk("after_rst_pass", 32'(a_pass), 32'h1);

        for (int r = 0; r < 8; r++) begin
            f = no_fault();
            case ($urandom_range(0, 2))
                1: begin f.stk = 1; f.sa = 4'($urandom_range(0, 15)); f.sm = 32'h1 << $urandom_range(0, 31); end
                2: begin
                    f.al = 1; f.src = 4'($urandom_range(0, 15));
                    f.dst = f.src + 4'($urandom_range(1, 15));
                end
                default: ;
            endcase
            march_ref(32'h0, f, xp, xa, xd, xe);
            run(f, $urandom_range(0, 3), 0);
            chk($sformatf("rnd%0d_pass", r), 32'(a_pass), 32'(xp));
`ifdef DFFRAM_BIST_FAIL_LOG_EN
            if (!xp) begin
                chk($sformatf("rnd%0d_fail_addr", r), 32'(a_fa), 32'(xa));
                chk($sformatf("rnd%0d_fail_data", r), a_fd, xd);
                chk($sformatf("rnd%0d_fail_elem", r), 32'(a_fe), 32'(xe));
            end
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
